// File: rtl/perf_event_counter_bank.sv
// Performance event counter bank fed by the core trace bundle, with a
// single-cycle req/ack register port, sticky overflow status and a level IRQ.

package perf_trace_pkg;
  typedef struct packed {
    logic       operand_stall;
    logic       unit_stall;
    logic       no_id_stall;
    logic       no_instruction_stall;
    logic       other_stall;
    logic       instruction_issued_dec;
    logic       branch_operand_stall;
    logic       alu_operand_stall;
    logic       ls_operand_stall;
    logic       div_operand_stall;
    logic       alu_op;
    logic       branch_or_jump_op;
    logic       load_op;
    logic       store_op;
    logic       mul_op;
    logic       div_op;
    logic       misc_op;
    logic       branch_correct;
    logic       branch_misspredict;
    logic       return_correct;
    logic       return_misspredict;
    logic       rs1_forwarding_needed;
    logic       rs2_forwarding_needed;
    logic       rs1_and_rs2_forwarding_needed;
    logic [2:0] num_instructions_completing;
  } trace_events_t;

  typedef struct packed {
    trace_events_t events;
  } trace_outputs_t;
endpackage

module perf_event_counter_bank
  import perf_trace_pkg::*;
#(
  parameter int unsigned COUNTER_WIDTH = 32,
  parameter int unsigned ADDR_W        = 6
) (
  input  logic                     clk,
  input  logic                     rst,
  input  trace_outputs_t           tr,
  input  logic                     req,
  input  logic                     we,
  input  logic [ADDR_W-1:0]        addr,
  input  logic [COUNTER_WIDTH-1:0] wdata,
  output logic                     ack,
  output logic [COUNTER_WIDTH-1:0] rdata,
  output logic                     overflow_irq
);

  localparam int unsigned NUM_CNT = 26;
  localparam logic [ADDR_W-1:0] ADDR_CTRL = ADDR_W'(8'h3C);
  localparam logic [ADDR_W-1:0] ADDR_OVF  = ADDR_W'(8'h3D);

  logic [COUNTER_WIDTH-1:0] cnt_q [NUM_CNT];
  logic [COUNTER_WIDTH-1:0] cnt_d [NUM_CNT];
  logic [NUM_CNT-1:0]       ovf_q, ovf_d;
  logic [NUM_CNT-1:0]       ev_bits, carry, cnt_wr, ovf_wmask;
  logic                     en_q, en_d, freeze_q, freeze_d, irq_en_q, irq_en_d;
  logic                     ack_q, ack_d, irq_q, irq_d;
  logic [COUNTER_WIDTH-1:0] rdata_q, rdata_d, rd_word, inc;
  logic [COUNTER_WIDTH:0]   sum;
  logic                     ctrl_wr, ovf_wr, clr;

  // Bit 0 drives the cycle counter; bit 1 stays 0 because retired
  // takes the multi-bit completion count instead.
  always_comb begin
    ev_bits      = '0;
    ev_bits[0]   = 1'b1;
    ev_bits[2]   = tr.events.operand_stall;
    ev_bits[3]   = tr.events.unit_stall;
    ev_bits[4]   = tr.events.no_id_stall;
    ev_bits[5]   = tr.events.no_instruction_stall;
    ev_bits[6]   = tr.events.other_stall;
    ev_bits[7]   = tr.events.instruction_issued_dec;
    ev_bits[8]   = tr.events.branch_operand_stall;
    ev_bits[9]   = tr.events.alu_operand_stall;
    ev_bits[10]  = tr.events.ls_operand_stall;
    ev_bits[11]  = tr.events.div_operand_stall;
    ev_bits[12]  = tr.events.alu_op;
    ev_bits[13]  = tr.events.branch_or_jump_op;
    ev_bits[14]  = tr.events.load_op;
    ev_bits[15]  = tr.events.store_op;
    ev_bits[16]  = tr.events.mul_op;
    ev_bits[17]  = tr.events.div_op;
    ev_bits[18]  = tr.events.misc_op;
    ev_bits[19]  = tr.events.branch_correct;
    ev_bits[20]  = tr.events.branch_misspredict;
    ev_bits[21]  = tr.events.return_correct;
    ev_bits[22]  = tr.events.return_misspredict;
    ev_bits[23]  = tr.events.rs1_forwarding_needed;
    ev_bits[24]  = tr.events.rs2_forwarding_needed;
    ev_bits[25]  = tr.events.rs1_and_rs2_forwarding_needed;
  end

  always_comb begin
    ctrl_wr   = req & we & (addr == ADDR_CTRL);
    ovf_wr    = req & we & (addr == ADDR_OVF);
    clr       = ctrl_wr & wdata[1];
    ovf_wmask = NUM_CNT'(wdata);
    carry     = '0;
    cnt_wr    = '0;
    inc       = '0;
    sum       = '0;
    for (int unsigned i = 0; i < NUM_CNT; i++) begin
      cnt_wr[i] = req & we & (addr == ADDR_W'(i));
      inc       = (i == 1) ? COUNTER_WIDTH'(tr.events.num_instructions_completing)
                           : COUNTER_WIDTH'(ev_bits[i]);
      sum       = {1'b0, cnt_q[i]} + {1'b0, inc};
      cnt_d[i]  = cnt_q[i];
      if (clr) begin
        cnt_d[i] = '0;
      end else if (cnt_wr[i]) begin
        cnt_d[i] = wdata;
      end else if (en_q) begin
        cnt_d[i] = sum[COUNTER_WIDTH-1:0];
        carry[i] = sum[COUNTER_WIDTH];
      end
    end

    // Clear is applied before set so a same-edge overflow survives W1C.
    ovf_d = ovf_q;
    if (ovf_wr) ovf_d = ovf_d & ~ovf_wmask;
    ovf_d = ovf_d | carry;
    if (clr) ovf_d = '0;

    en_d     = en_q;
    freeze_d = freeze_q;
    irq_en_d = irq_en_q;
    if (ctrl_wr) begin
      en_d     = wdata[0];
      freeze_d = wdata[2];
      irq_en_d = wdata[3];
    end
    if (freeze_q && (|carry)) en_d = 1'b0;

    rd_word = '0;
    for (int unsigned i = 0; i < NUM_CNT; i++) begin
      if (addr == ADDR_W'(i)) rd_word = cnt_q[i];
    end
    if (addr == ADDR_CTRL) rd_word = COUNTER_WIDTH'({irq_en_q, freeze_q, 1'b0, en_q});
    if (addr == ADDR_OVF)  rd_word = COUNTER_WIDTH'(ovf_q);

    ack_d   = req;
    rdata_d = (req && !we) ? rd_word : '0;
    irq_d   = irq_en_d & (|ovf_d);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_CNT; i++) cnt_q[i] <= '0;
      ovf_q    <= '0;
      en_q     <= 1'b1;
      freeze_q <= 1'b0;
      irq_en_q <= 1'b0;
      ack_q    <= 1'b0;
      rdata_q  <= '0;
      irq_q    <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      ovf_q    <= ovf_d;
      en_q     <= en_d;
      freeze_q <= freeze_d;
      irq_en_q <= irq_en_d;
      ack_q    <= ack_d;
      rdata_q  <= rdata_d;
      irq_q    <= irq_d;
    end
  end

  assign ack          = ack_q;
  assign rdata        = rdata_q;
  assign overflow_irq = irq_q;

endmodule

// File: tb/tb_perf_event_counter_bank.sv
// Scoreboard bench for perf_event_counter_bank: each access pushes its
// expected rdata, the ack monitor pops and compares.

module tb_perf_event_counter_bank;
  import perf_trace_pkg::*;

  localparam int unsigned CW = 32;

  logic           clk = 1'b0;
  logic           rst;
  logic           req;
  logic           we;
  logic [5:0]     addr;
  logic [CW-1:0]  wdata;
  logic           ack;
  logic [CW-1:0]  rdata;
  logic           irq;
  trace_outputs_t tr;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string         tag;
    logic [CW-1:0] val;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  always #5 clk = ~clk;

  perf_event_counter_bank #(
    .COUNTER_WIDTH(CW),
    .ADDR_W       (6)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .tr          (tr),
    .req         (req),
    .we          (we),
    .addr        (addr),
    .wdata       (wdata),
    .ack         (ack),
    .rdata       (rdata),
    .overflow_irq(irq)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (ack === 1'b1) begin
      if (sb.size() == 0) begin
        check("spurious_ack", 64'(ack), 64'(0));
      end else begin
        mon_e = sb.pop_front();
        check(mon_e.tag, 64'(rdata), 64'(mon_e.val));
      end
    end
  end

  task automatic rd(input logic [5:0] a, input logic [CW-1:0] exp, input string tag);
    req   = 1'b1;
    we    = 1'b0;
    addr  = a;
    wdata = '0;
    sb.push_back('{tag, exp});
    @(posedge clk); #1;
    req = 1'b0;
  endtask

  task automatic wr(input logic [5:0] a, input logic [CW-1:0] d, input string tag);
    req   = 1'b1;
    we    = 1'b1;
    addr  = a;
    wdata = d;
    sb.push_back('{tag, '0});
    @(posedge clk); #1;
    req = 1'b0;
    we  = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    rst   = 1'b1;
    req   = 1'b0;
    we    = 1'b0;
    addr  = '0;
    wdata = '0;
    tr    = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ack",   64'(ack),   64'(0));
    check("rst_rdata", 64'(rdata), 64'(0));
    check("rst_irq",   64'(irq),   64'(0));
    rst = 1'b0;

    idle(10);
    rd(6'd0, 32'd10, "cycles_idle");
    rd(6'd2, 32'd0,  "operand_stall_idle");

    tr.events.alu_op = 1'b1;
    tr.events.num_instructions_completing = 3'd2;
    idle(5);
    tr = '0;
    rd(6'd12,  32'd5,  "alu_op_cnt");
    rd(6'd1,   32'd10, "retired_cnt");
    rd(6'h3C,  32'h1,  "ctrl_reset_val");

    wr(6'h3C, 32'h9, "wr_ctrl_irq_en");
    wr(6'd1, 32'hFFFF_FFFE, "wr_retired");
    check("irq_before_ovf", 64'(irq), 64'(0));
    tr.events.num_instructions_completing = 3'd3;
    @(posedge clk); #1;
    tr = '0;
    check("irq_after_ovf", 64'(irq), 64'(1));
    rd(6'd1,  32'd1, "retired_wrap");
    rd(6'h3D, 32'h2, "ovf_bit1");
    wr(6'h3D, 32'h2, "w1c_ovf");
    check("irq_after_w1c", 64'(irq), 64'(0));
    rd(6'h3D, 32'h0, "ovf_cleared");

    wr(6'h3C, 32'h5, "wr_ctrl_freeze");
    wr(6'd0, 32'hFFFF_FFFF, "wr_cycles_max");
    idle(1);
    rd(6'h3C, 32'h4, "ctrl_frozen");
    rd(6'd0,  32'd0, "cycles_wrapped");
    idle(20);
    rd(6'd0,  32'd0, "cycles_held");
    rd(6'h3D, 32'h1, "ovf_bit0");
    check("irq_masked", 64'(irq), 64'(0));

    wr(6'h3C, 32'h1, "wr_ctrl_en");
    tr.events.unit_stall = 1'b1;
    tr.events.no_instruction_stall = 1'b1;
    wr(6'd5, 32'd100, "wr_cnt5");
    tr = '0;
    rd(6'd5,  32'd100, "write_beats_inc");
    rd(6'd3,  32'd1,   "unit_stall_cnt");
    rd(6'h20, 32'd0,   "unmapped_rd");
    wr(6'h21, 32'hDEAD, "unmapped_wr");
    rd(6'h3E, 32'd0,   "unmapped_rd2");

    wr(6'h3C, 32'h3, "wr_ctrl_clr");
    rd(6'd0,  32'd0, "clr_cycles");
    rd(6'd5,  32'd0, "clr_cnt5");
    rd(6'd1,  32'd0, "clr_retired");
    rd(6'h3D, 32'd0, "clr_ovf");
    rd(6'h3C, 32'h1, "ctrl_after_clr");

    tr.events.alu_op = 1'b1;
    idle(3);
    tr = '0;
    rst  = 1'b1;
    req  = 1'b1;
    we   = 1'b0;
    addr = 6'd12;
    @(posedge clk); #1;
    req = 1'b0;
    check("ack_dropped", 64'(ack), 64'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    rd(6'd0,  32'd0, "post_rst_cycles");
    rd(6'd12, 32'd0, "post_rst_alu_op");
    rd(6'd3,  32'd0, "post_rst_unit_stall");
    rd(6'h3C, 32'h1, "post_rst_ctrl");
    idle(3);
    check("sb_drained", 64'(sb.size()), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
